// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared types and constants for the shared-adder sequencer.
//   state_t    : controller FSM states (IDLE, CALC, RESP)
//   N_BITS_DEF : default operand/sum width
//   flags_t    : result flags {n, z, p}, plus ovf when ADDER_SHARE_OVF_EN is defined
package adder_share_pkg;

    localparam int N_BITS_DEF = 8;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    typedef struct packed {
`ifdef ADDER_SHARE_OVF_EN
        logic ovf;
`endif
        logic n;
        logic z;
        logic p;
    } flags_t;

endpackage

// File: rtl/adder_flags_unit.sv
// adder_flags_unit: combinational signed adder with N/Z/P (and optional overflow) flags.
//   a, b  in  N_BITS  two's complement operands
//   sum   out N_BITS  a+b wrapped modulo 2^N_BITS
//   flags out flags_t n = sign of sum, z = sum is zero, p = sum is even,
//                     ovf = signed overflow (only with ADDER_SHARE_OVF_EN)
module adder_flags_unit
    import adder_share_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] sum,
    output flags_t            flags
);

    always_comb begin
        sum     = a + b;
        flags   = '0;
        flags.n = sum[N_BITS-1];
        flags.z = (sum == '0);
        flags.p = ~sum[0];
`ifdef ADDER_SHARE_OVF_EN
        // overflow: operands share a sign that the wrapped sum does not
        flags.ovf = (a[N_BITS-1] == b[N_BITS-1]) && (sum[N_BITS-1] != a[N_BITS-1]);
`endif
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: round-robin sequencer sharing one signed adder among N_REQ requesters.
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    per-requester handshake; req_ready is one-hot or zero, only in IDLE
//   req_a, req_b       per-requester signed operands
//   rsp_valid/ready    single response handshake, outputs held until accepted
//   rsp_id             requester owning the result
//   rsp_sum            wrapped signed sum
//   rsp_n/z/p          negative / zero / even flags
//   rsp_ovf            signed overflow, present only when ADDER_SHARE_OVF_EN is defined
// One operation in flight: accept (IDLE) -> compute (CALC) -> respond (RESP).
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int N_REQ  = 2,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0][N_BITS-1:0]  req_a,
    input  logic [N_REQ-1:0][N_BITS-1:0]  req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [N_BITS-1:0]             rsp_sum,
`ifdef ADDER_SHARE_OVF_EN
    output logic                          rsp_ovf,
`endif
    output logic                          rsp_n,
    output logic                          rsp_z,
    output logic                          rsp_p
);

    state_t            state, next_state;
    logic [ID_W-1:0]   last_grant, grant, lo_idx, hi_idx, lat_id;
    logic              any_valid, hi_found;
    logic [N_BITS-1:0] lat_a, lat_b, sum;
    flags_t            flags, rsp_flags;

    // Round robin: lowest valid index above last_grant, else lowest valid index (wrap).
    always_comb begin
        any_valid = 1'b0;
        hi_found  = 1'b0;
        lo_idx    = '0;
        hi_idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid = 1'b1;
                lo_idx    = ID_W'(i);
                if (i > int'(last_grant)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        grant = hi_found ? hi_idx : lo_idx;
    end

    // Gated by rst_n so the accept strobe is also silent while reset is held.
    assign req_ready = (rst_n && state == IDLE && any_valid) ? N_REQ'(1) << grant : '0;
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = any_valid ? CALC : IDLE;
            CALC:    next_state = RESP;
            RESP:    next_state = rsp_ready ? IDLE : RESP;
            default: next_state = IDLE;
        endcase
    end

    adder_flags_unit #(.N_BITS(N_BITS)) u_add (
        .a     (lat_a),
        .b     (lat_b),
        .sum   (sum),
        .flags (flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_a      <= '0;
            lat_b      <= '0;
            lat_id     <= '0;
            last_grant <= ID_W'(N_REQ - 1);
            rsp_id     <= '0;
            rsp_sum    <= '0;
            rsp_flags  <= '0;
        end else begin
            if (state == IDLE && any_valid) begin
                lat_a  <= req_a[grant];
                lat_b  <= req_b[grant];
                lat_id <= grant;
            end
            if (state == CALC) begin
                rsp_sum    <= sum;
                rsp_flags  <= flags;
                rsp_id     <= lat_id;
                last_grant <= lat_id;
            end
        end
    end

    assign rsp_n = rsp_flags.n;
    assign rsp_z = rsp_flags.z;
    assign rsp_p = rsp_flags.p;
`ifdef ADDER_SHARE_OVF_EN
    assign rsp_ovf = rsp_flags.ovf;
`endif

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: self-checking bench for adder_share_ctrl against an arithmetic reference model.
module tb_adder_share_ctrl;

    localparam int N_BITS = 8;
    localparam int N_REQ  = 2;
    localparam int ID_W   = 1;
    localparam int MASK   = (1 << N_BITS) - 1;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic [N_REQ-1:0]             req_valid = '0;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0][N_BITS-1:0] req_a = '0;
    logic [N_REQ-1:0][N_BITS-1:0] req_b = '0;
    logic                         rsp_valid;
    logic                         rsp_ready = 1'b0;
    logic [ID_W-1:0]              rsp_id;
    logic [N_BITS-1:0]            rsp_sum;
    logic                         rsp_n, rsp_z, rsp_p;
`ifdef ADDER_SHARE_OVF_EN
    logic                         rsp_ovf;
`endif

    int tests = 0;
    int fails = 0;
    int hs = 0;
    int model_last = N_REQ - 1;
    int op_a [N_REQ];
    int op_b [N_REQ];

    adder_share_ctrl #(.N_BITS(N_BITS), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
`ifdef ADDER_SHARE_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .rsp_n     (rsp_n),
        .rsp_z     (rsp_z),
        .rsp_p     (rsp_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && rsp_valid && rsp_ready) hs++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N_REQ-1:0] v);
        for (int k = 1; k <= N_REQ; k++)
            if (v[(model_last + k) % N_REQ]) return (model_last + k) % N_REQ;
        return -1;
    endfunction

    // One full operation starting at an IDLE cycle; hold = cycles spent in RESP with rsp_ready low.
    task automatic run_op(input logic [N_REQ-1:0] v, input int hold);
        int g, s, ws, h0;
        g = pick(v);
        s = op_a[g] + op_b[g];
        ws = s;
        if (ws > (1 << (N_BITS - 1)) - 1) ws -= (1 << N_BITS);
        if (ws < -(1 << (N_BITS - 1))) ws += (1 << N_BITS);
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i] = N_BITS'(op_a[i]);
            req_b[i] = N_BITS'(op_b[i]);
        end
        req_valid = v;
        rsp_ready = (hold == 0);
        #1;
        check("grant", 32'(req_ready), 32'(1 << g));
        check("idle_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        check("calc_req_ready", 32'(req_ready), 0);
        check("calc_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_sum", 32'(rsp_sum), 32'(ws & MASK));
        check("rsp_n", 32'(rsp_n), 32'(ws < 0));
        check("rsp_z", 32'(rsp_z), 32'(ws == 0));
        check("rsp_p", 32'(rsp_p), 32'(ws % 2 == 0));
`ifdef ADDER_SHARE_OVF_EN
        check("rsp_ovf", 32'(rsp_ovf), 32'(s != ws));
`endif
        check("resp_req_ready", 32'(req_ready), 0);
        for (int c = 1; c < hold; c++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_id", 32'(rsp_id), 32'(g));
            check("bp_sum", 32'(rsp_sum), 32'(ws & MASK));
            check("bp_flags", 32'({rsp_n, rsp_z, rsp_p}), 32'({ws < 0, ws == 0, ws % 2 == 0}));
            check("bp_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        h0 = hs;
        @(posedge clk); #1;
        check("handshake_count", 32'(hs - h0), 1);
        check("post_rsp_valid", 32'(rsp_valid), 0);
        req_valid = '0;
        model_last = g;
    endtask

    initial begin
        int g, h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_rsp_id", 32'(rsp_id), 0);
        check("reset_rsp_sum", 32'(rsp_sum), 0);
        check("reset_flags", 32'({rsp_n, rsp_z, rsp_p}), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_req", 32'(req_ready), 0);

        op_a = '{5, 0};    op_b = '{3, 0};  run_op(2'b01, 0);
        op_a = '{0, -7};   op_b = '{0, 2};  run_op(2'b10, 0);
        op_a = '{127, 9};  op_b = '{1, 9};  run_op(2'b01, 0);
        op_a = '{9, -4};   op_b = '{9, 4};  run_op(2'b10, 0);

        for (int k = 0; k < 4; k++) begin
            op_a = '{int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128};
            op_b = '{int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128};
            run_op(2'b11, 0);
        end

        op_a = '{10, 30}; op_b = '{20, 40}; run_op(2'b11, 5);

        // reset while the accepted operation is in CALC
        op_a = '{1, 50}; op_b = '{2, 60};
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        g = pick(req_valid);
        #1;
        check("rst_grant", 32'(req_ready), 32'(1 << g));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_sum", 32'(rsp_sum), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_flags", 32'({rsp_n, rsp_z, rsp_p}), 0);
        req_valid = '0;
        @(negedge clk) rst_n = 1'b1;
        model_last = N_REQ - 1;
        h0 = hs;
        repeat (4) @(posedge clk);
        #1;
        check("no_rsp_after_rst", 32'(hs - h0), 0);
        check("no_valid_after_rst", 32'(rsp_valid), 0);
        op_a = '{-1, -2}; op_b = '{-3, -4}; run_op(2'b11, 0);

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                op_a[i] = int'($urandom_range(0, 255)) - 128;
                op_b[i] = int'($urandom_range(0, 255)) - 128;
            end
            run_op(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
